// File: rtl/bound_ctrl.sv
// Post-accumulation clamp sequencer: optional ReLU, symmetric bound,
// narrowing to D_BW, streamed downstream with last/done signalling.
module bound_ctrl #(
  parameter int D_BW   = 8,
  parameter int AB_BW  = 21,
  parameter int LEN_BW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_BW-1:0] i_len,
  input  logic [1:0]        i_bnd_sel,
  input  logic              i_relu_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AB_BW-1:0]  i_acc_bias,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [D_BW-1:0]   o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, nxt;

  logic [LEN_BW-1:0] len_q;
  logic [LEN_BW-1:0] in_cnt;
  logic [LEN_BW-1:0] out_cnt;
  logic [1:0]        bnd_q;
  logic              relu_q;

  logic up_xfer;
  logic dn_xfer;
  logic in_last;
  logic out_last;

  logic signed [AB_BW-1:0] v;
  logic signed [AB_BW-1:0] mx;
  logic signed [AB_BW-1:0] mn;
  logic [D_BW-1:0]         d_nxt;

  assign in_last  = in_cnt == len_q - LEN_BW'(1);
  assign out_last = out_cnt == len_q - LEN_BW'(1);
  assign up_xfer  = i_valid && o_ready;
  assign dn_xfer  = (state == RUN) && o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (i_start)
          nxt = (i_len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (dn_xfer && out_last)
          nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (state)
      RUN: begin
        o_busy  = 1'b1;
        o_ready = (in_cnt < len_q) &&
                  (!o_valid || i_ready);
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // MIN is the bitwise complement of MAX for these power-of-two bounds
  always_comb begin
    v = $signed(i_acc_bias);
    if (relu_q && v[AB_BW-1])
      v = '0;
    mx = (AB_BW'(8) << bnd_q) - AB_BW'(1);
    mn = ~mx;
    if (v < mn)      d_nxt = mn[D_BW-1:0];
    else if (v > mx) d_nxt = mx[D_BW-1:0];
    else             d_nxt = v[D_BW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      bnd_q   <= '0;
      relu_q  <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (state == IDLE) begin
      if (i_start && i_len != '0) begin
        len_q   <= i_len;
        bnd_q   <= i_bnd_sel;
        relu_q  <= i_relu_en;
        in_cnt  <= '0;
        out_cnt <= '0;
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end else if (state == RUN) begin
      if (up_xfer) begin
        o_data  <= d_nxt;
        o_valid <= 1'b1;
        o_last  <= in_last;
        in_cnt  <= in_cnt + LEN_BW'(1);
      end else if (dn_xfer) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (dn_xfer)
        out_cnt <= out_cnt + LEN_BW'(1);
    end
  end

endmodule
